// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-channel synchroniser, debouncer and press/release/long/repeat strobes
module button_conditioner #(
    parameter int WIDTH      = 4,
    parameter int COUNT_MAX  = 2_000_000,
    parameter int HOLD_MAX   = 100_000_000,
    parameter int REPEAT_MAX = 25_000_000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] noisy_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_out,
    output logic [WIDTH-1:0] fall_out,
    output logic [WIDTH-1:0] long_out,
    output logic [WIDTH-1:0] repeat_out
);

    localparam int CW = ($clog2(COUNT_MAX + 1) < 1) ? 1 : $clog2(COUNT_MAX + 1);
    localparam int HW = ($clog2(HOLD_MAX + 1) < 1) ? 1 : $clog2(HOLD_MAX + 1);
    localparam int RW = ($clog2(REPEAT_MAX + 1) < 1) ? 1 : $clog2(REPEAT_MAX + 1);

    localparam logic [CW-1:0] COUNT_LAST  = CW'(COUNT_MAX - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_MAX - 1);
    localparam logic [RW-1:0] REPEAT_LAST = RW'((REPEAT_MAX > 0) ? REPEAT_MAX - 1 : 0);
    localparam bit            REPEAT_EN   = (REPEAT_MAX > 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } chan_state_t;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        logic          sync1;
        logic          sync2;
        logic          stable;
        logic [CW-1:0] deb_cnt;
        logic [HW-1:0] hold_cnt;
        logic [RW-1:0] rep_cnt;
        logic          rise_q;
        logic          fall_q;
        logic          long_q;
        logic          rep_q;
        chan_state_t   state;
        chan_state_t   state_nxt;
        logic          flip;
        logic          rise_evt;
        logic          fall_evt;
        logic          long_evt;
        logic          rep_evt;

        // Events are decided one cycle ahead so the strobes land on the edge that
        // changes the level; a release on that edge always wins over long/repeat.
        always_comb begin
            flip      = 1'b0;
            rise_evt  = 1'b0;
            fall_evt  = 1'b0;
            long_evt  = 1'b0;
            rep_evt   = 1'b0;
            state_nxt = state;

            flip     = (sync2 != stable) && (deb_cnt == COUNT_LAST);
            rise_evt = flip && sync2;
            fall_evt = flip && !sync2;
            long_evt = (state == ST_PRESSED) && !fall_evt && (hold_cnt == HOLD_LAST);
            rep_evt  = REPEAT_EN && (state == ST_HELD) && !fall_evt && (rep_cnt == REPEAT_LAST);

            case (state)
                ST_IDLE: begin
                    if (rise_evt) begin
                        state_nxt = ST_PRESSED;
                    end
                end
                ST_PRESSED: begin
                    if (fall_evt) begin
                        state_nxt = ST_IDLE;
                    end else if (long_evt) begin
                        state_nxt = ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (fall_evt) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync1    <= 1'b0;
                sync2    <= 1'b0;
                stable   <= 1'b0;
                deb_cnt  <= '0;
                hold_cnt <= '0;
                rep_cnt  <= '0;
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
                long_q   <= 1'b0;
                rep_q    <= 1'b0;
                state    <= ST_IDLE;
            end else begin
                sync1 <= noisy_in[i];
                sync2 <= sync1;

                // Any cycle of agreement throws away the partial count.
                if ((sync2 == stable) || flip) begin
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
                if (flip) begin
                    stable <= sync2;
                end

                // Hold count only advances while pressed; it parks at HOLD_MAX once held.
                if ((state == ST_IDLE) || fall_evt) begin
                    hold_cnt <= '0;
                end else if (state == ST_PRESSED) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end

                if (!REPEAT_EN || (state != ST_HELD) || fall_evt || rep_evt) begin
                    rep_cnt <= '0;
                end else begin
                    rep_cnt <= rep_cnt + 1'b1;
                end

                rise_q <= rise_evt;
                fall_q <= fall_evt;
                long_q <= long_evt;
                rep_q  <= rep_evt;
                state  <= state_nxt;
            end
        end

        assign clean_out[i]  = stable;
        assign rise_out[i]   = rise_q;
        assign fall_out[i]   = fall_q;
        assign long_out[i]   = long_q;
        assign repeat_out[i] = rep_q;
    end

endmodule
